sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares one single-port synchronous SRAM (1-cycle read latency) between the fetch stage (read-only) and the memory stage (read/write, byte enables).
- Sits between the pipeline core and the SoC memory port, replacing separate inst/data SRAM ports.
- Grants at most one access per cycle, gives fixed priority to the memory stage with anti-starvation for fetch, and routes each read response back to its owner.
- On a pipeline cancel, it discards an in-flight fetch response.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MAX_STARVE, 4, consecutive memory-stage grants allowed while fetch waits before fetch is forced; range 1..15

Ports:
- clk  in  1  clock
- reset  in  1  one clock; reset is synchronous and active-high
- cancel  in  1  pipeline flush; kills an outstanding fetch response
- if_req  in  1  fetch read request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid (registered)
- if_rdata  out  DATA_W  fetch read data
- mem_req  in  1  memory-stage request; held with addr/wen/wdata until mem_gnt
- mem_addr  in  ADDR_W  memory-stage byte address
- mem_wen  in  DATA_W/8  byte write enables; 0 means read
- mem_wdata  in  DATA_W  write data
- mem_gnt  out  1  memory-stage request accepted this cycle (combinational)
- mem_rvalid  out  1  memory-stage read data valid (registered; reads only)
- mem_rdata  out  DATA_W  memory-stage read data
- sram_en  out  1  SRAM enable
- sram_wen  out  DATA_W/8  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address (byte address, passed through)
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read enable

Behaviour:
- Grant is combinational:
  - sel_mem = mem_req & ~(if_req & starve_cnt==MAX_STARVE).
  - sel_if = if_req & ~sel_mem.
  - mem_gnt = sel_mem; if_gnt = sel_if.
  - While reset=1, both grants and sram_en are 0.
- SRAM port:
  - sram_en = sel_mem|sel_if.
  - Address and data are muxed from the selected requester.
  - sram_wen = mem_wen when sel_mem, else 0.
  - sram_wdata = mem_wdata when sel_mem, else 0.
  - With no grant, addr and wdata are 0.
- Starvation counter starve_cnt (4 bits):
  - Increments when sel_mem & if_req.
  - Clears to 0 when sel_if, or when if_req=0.
  - Saturates at MAX_STARVE.
  - When it reaches MAX_STARVE, the next cycle with if_req=1 grants fetch regardless of mem_req.
- Response owner register resp_own ∈ {NONE, IF, MEM}, updated every cycle:
  - IF if sel_if.
  - MEM if sel_mem & mem_wen==0.
  - NONE otherwise (idle, or a write).
- Read responses (next cycle):
  - if_rvalid = (resp_own==IF) & ~kill_if.
  - mem_rvalid = (resp_own==MEM).
  - if_rdata = mem_rdata = sram_rdata, unqualified; consumers sample only on rvalid.
- Read latency: exactly 1 cycle from grant to rvalid.
- Back-to-back grants are allowed every cycle; at most one outstanding response.
- Writes:
  - Complete in the grant cycle; no response is produced.
  - Write-then-read to the same address on consecutive cycles returns the new data (SRAM write-first behaviour required of the macro).
- cancel:
  - If cancel is asserted in the cycle a fetch is granted, that response is suppressed.
  - kill_if is registered from cancel & sel_if.
  - If cancel is asserted in the cycle if_rvalid would be high, if_rvalid is still suppressed (combinational mask).
  - cancel never affects memory-stage requests or responses, and does not block if_gnt.
- Reset:
  - resp_own=NONE, starve_cnt=0, kill_if=0.
  - if_rvalid=0, mem_rvalid=0, gnt=0, sram_en=0.
  - Reset during an outstanding read drops the response.
- Simultaneous requests: memory stage wins unless the starvation threshold is hit.
- Requesters must accept rvalid unconditionally; there is no response backpressure.

Decomposition:
- Shared package holds:
  - Owner encoding OWN_NONE=2'd0, OWN_IF=2'd1, OWN_MEM=2'd2.
  - Default widths ADDR_W/DATA_W.
  - STARVE_CNT_W=4.
- One sub-module is natural: sram_arb_prio, the combinational priority plus starvation counter, with outputs sel_if/sel_mem.
- Response routing stays in the top level.

Test Plan:
- Single requester, fetch only: if_req=1, if_addr=0xBFC00000, SRAM returns 0x3C1D0001 -> if_gnt=1 same cycle, if_rvalid=1 with if_rdata=0x3C1D0001 next cycle; mem_rvalid=0.
- Memory-stage write then read: mem_req=1, mem_wen=4'hF, mem_addr=0x100, mem_wdata=0xDEADBEEF, then a read of 0x100 -> sram_wen=4'hF in the write cycle and no mem_rvalid; next cycle sram_en=1, sram_wen=0; the following cycle mem_rvalid=1, mem_rdata=0xDEADBEEF.
- Contention/starvation with MAX_STARVE=4: if_req and mem_req held high for 10 cycles -> grants are M,M,M,M,I,M,M,M,M,I; starve_cnt reaches 4 before each fetch grant.
- Cancel on in-flight fetch: fetch granted at cycle t with cancel=1 at t -> if_rvalid=0 at t+1. Repeat with cancel=1 only at t+1 -> if_rvalid=0 at t+1. A memory-stage read granted at t+1 still gives mem_rvalid=1 at t+2.
- Reset mid-read: memory-stage read granted at t, reset=1 at t+1 -> mem_rvalid=0 at t+1 and t+2, starve_cnt=0, and all grants are 0 while reset=1.
- Byte-enable write: mem_wen=4'b0011, mem_wdata=0x0000ABCD -> sram_wen=4'b0011, sram_wdata=0x0000ABCD, if_gnt=0 that cycle even with if_req=1 (starve_cnt<4).

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter slice.
// Holds the default address/data widths, the width of the fetch starvation
// counter and the encoding of the response-owner register, so the top level
// and the priority sub-module agree on them.
package sram_arbiter_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } own_e;

endpackage

// File: rtl/sram_arb_prio.sv
// Grant priority between the fetch stage and the memory stage.
// The memory stage wins by default; once it has been granted MAX_STARVE
// times in a row while fetch was waiting, the next cycle with a fetch request
// goes to fetch regardless.
// Ports:
//   clk_i, reset_i     clock and synchronous active-high reset
//   ifReq_i, memReq_i  raw requests from fetch and memory stage
//   selIf_o, selMem_o  combinational one-hot (or zero) selection
module sram_arb_prio
    import sram_arbiter_pkg::*;
#(
    parameter int MAX_STARVE = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic ifReq_i,
    input  logic memReq_i,
    output logic selIf_o,
    output logic selMem_o
);

    localparam logic [STARVE_CNT_W-1:0] MAX_CNT = STARVE_CNT_W'(MAX_STARVE);
    localparam logic [STARVE_CNT_W-1:0] CNT_ONE = STARVE_CNT_W'(1);

    logic [STARVE_CNT_W-1:0] starveCnt_q, starveCnt_d;
    logic                    forceIf;

    // Selection is masked by reset so nothing reaches the SRAM while the
    // pipeline is being reset, even if requests are still asserted.
    always_comb begin
        forceIf  = ifReq_i && (starveCnt_q == MAX_CNT);
        selMem_o = !reset_i && memReq_i && !forceIf;
        selIf_o  = !reset_i && ifReq_i && !selMem_o;
    end

    // The counter only tracks an unbroken run of memory grants that made
    // fetch wait; any fetch grant or a cycle without a fetch request ends
    // the run. It saturates at the threshold instead of wrapping.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (selIf_o || !ifReq_i) begin
            starveCnt_d = '0;
        end else if (selMem_o && (starveCnt_q != MAX_CNT)) begin
            starveCnt_d = starveCnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starveCnt_q <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port synchronous SRAM (1-cycle read latency) between the
// fetch stage (read-only) and the memory stage (read/write with byte enables).
// At most one access is granted per cycle; each read response is routed back
// to its owner one cycle after the grant. A pipeline cancel suppresses an
// in-flight fetch response.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   cancel                              pipeline flush, kills fetch response
//   if_req/if_addr/if_gnt               fetch request channel
//   if_rvalid/if_rdata                  fetch response
//   mem_req/mem_addr/mem_wen/mem_wdata  memory-stage request channel
//   mem_gnt                             memory-stage accept
//   mem_rvalid/mem_rdata                memory-stage read response
//   sram_en/sram_wen/sram_addr/sram_wdata/sram_rdata  SRAM macro port
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_STARVE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cancel,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                mem_req,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W/8-1:0] mem_wen,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_gnt,
    output logic                mem_rvalid,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_wen,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    logic selIf, selMem;
    own_e respOwn_q, respOwn_d;
    logic killIf_q;

    sram_arb_prio #(
        .MAX_STARVE (MAX_STARVE)
    ) u_prio (
        .clk_i    (clk),
        .reset_i  (reset),
        .ifReq_i  (if_req),
        .memReq_i (mem_req),
        .selIf_o  (selIf),
        .selMem_o (selMem)
    );

    // SRAM port mux: only a memory-stage grant may write, and an idle port
    // drives zeros so the macro inputs never carry stale request data.
    always_comb begin
        sram_en    = selIf || selMem;
        sram_wen   = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (selMem) begin
            sram_wen   = mem_wen;
            sram_addr  = mem_addr;
            sram_wdata = mem_wdata;
        end else if (selIf) begin
            sram_addr  = if_addr;
        end
        if_gnt  = selIf;
        mem_gnt = selMem;
    end

    // Writes produce no response, so only reads record an owner for the
    // data the SRAM returns next cycle.
    always_comb begin
        respOwn_d = OWN_NONE;
        if (selIf) begin
            respOwn_d = OWN_IF;
        end else if (selMem && (mem_wen == '0)) begin
            respOwn_d = OWN_MEM;
        end
    end

    // Owner and kill flag move with the SRAM pipeline stage; reset drops any
    // response that was in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            respOwn_q <= OWN_NONE;
            killIf_q  <= 1'b0;
        end else begin
            respOwn_q <= respOwn_d;
            killIf_q  <= cancel && selIf;
        end
    end

    // A cancel in the response cycle still masks the fetch response, and
    // reset masks both so a read granted just before reset never shows up.
    always_comb begin
        if_rvalid  = (respOwn_q == OWN_IF) && !killIf_q && !cancel && !reset;
        mem_rvalid = (respOwn_q == OWN_MEM) && !reset;
        if_rdata   = sram_rdata;
        mem_rdata  = sram_rdata;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter. Directed stimulus drives the request
// ports and checks grants and the SRAM port in the same cycle; every read
// that should produce a response pushes its expected owner and data into a
// queue, and an independent monitor pops and compares whenever an rvalid
// appears.
module tb_sram_arbiter;

    logic        clk;
    logic        reset;
    logic        cancel;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic        isIf;
        logic [31:0] data;
    } exp_t;

    exp_t expQ[$];

    logic [31:0] memArr [logic [31:0]];

    sram_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .MAX_STARVE (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cancel     (cancel),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port SRAM, write-first, one cycle read latency.
    always @(posedge clk) begin
        logic [31:0] w;
        if (sram_en) begin
            w = memArr.exists(sram_addr) ? memArr[sram_addr] : 32'h0;
            if (sram_wen != 4'h0) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wen[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
                end
                memArr[sram_addr] = w;
            end
            sram_rdata <= w;
        end
    end

    // Response monitor: every rvalid must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_rvalid && mem_rvalid) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL dualRvalid: if_rvalid=%0b mem_rvalid=%0b, required at most one", if_rvalid, mem_rvalid);
            end else if (if_rvalid || mem_rvalid) begin
                assertCount++;
                if (expQ.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL unexpectedRsp: if_rvalid=%0b mem_rvalid=%0b, required no response", if_rvalid, mem_rvalid);
                end else begin
                    e = expQ.pop_front();
                    if ((e.isIf != if_rvalid) || ((if_rvalid ? if_rdata : mem_rdata) != e.data)) begin
                        failCount++;
                        $display("[TB] FAIL rspData: got isIf=%0b data=%h, required isIf=%0b data=%h", if_rvalid, (if_rvalid ? if_rdata : mem_rdata), e.isIf, e.data);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic cncl,
                                 input logic ifR, input logic [31:0] ifA,
                                 input logic memR, input logic [31:0] memA,
                                 input logic [3:0] wen, input logic [31:0] wd);
        @(posedge clk);
        #1;
        reset     = rst;
        cancel    = cncl;
        if_req    = ifR;
        if_addr   = ifA;
        mem_req   = memR;
        mem_addr  = memA;
        mem_wen   = wen;
        mem_wdata = wd;
    endtask

    task automatic checkOutput(input string name, input logic eIf, input logic eMem,
                               input logic eEn, input logic [3:0] eWen,
                               input logic [31:0] eAddr, input logic [31:0] eWd);
        logic [70:0] act, exp;
        @(negedge clk);
        act = {if_gnt, mem_gnt, sram_en, sram_wen, sram_addr, sram_wdata};
        exp = {eIf, eMem, eEn, eWen, eAddr, eWd};
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got ifg=%0b memg=%0b en=%0b wen=%h addr=%h wd=%h, required ifg=%0b memg=%0b en=%0b wen=%h addr=%h wd=%h",
                     name, if_gnt, mem_gnt, sram_en, sram_wen, sram_addr, sram_wdata,
                     eIf, eMem, eEn, eWen, eAddr, eWd);
        end
    endtask

    task automatic expectRsp(input logic isIf, input logic [31:0] d);
        exp_t e;
        e.isIf = isIf;
        e.data = d;
        expQ.push_back(e);
    endtask

    task automatic idleCycle(input string name);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
        checkOutput(name, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    localparam logic [31:0] IF_A  = 32'hBFC0_0000;
    localparam logic [31:0] IF_D  = 32'h3C1D_0001;
    localparam logic [31:0] MEM_A = 32'h0000_0100;
    localparam logic [31:0] MEM_D = 32'hDEAD_BEEF;

    initial begin
        logic expMemSeq [10];
        expMemSeq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        reset = 1'b1; cancel = 1'b0; if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_addr = '0; mem_wen = '0; mem_wdata = '0;
        memArr[IF_A]         = IF_D;
        memArr[32'h0000_0200] = 32'h1122_3344;

        // Reset holds all grants and the SRAM enable low.
        applyStimulus(1, 0, 1, IF_A, 1, MEM_A, 4'h0, 32'h0);
        checkOutput("resetGrant0", 0, 0, 0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1, 0, 1, IF_A, 1, MEM_A, 4'h0, 32'h0);
        checkOutput("resetGrant1", 0, 0, 0, 4'h0, 32'h0, 32'h0);
        idleCycle("idleAfterReset");

        // Fetch only.
        applyStimulus(0, 0, 1, IF_A, 0, 32'h0, 4'h0, 32'h0);
        checkOutput("fetchOnly", 1, 0, 1, 4'h0, IF_A, 32'h0);
        expectRsp(1, IF_D);
        idleCycle("fetchIdle");

        // Memory-stage write then read of the same word.
        applyStimulus(0, 0, 0, 32'h0, 1, MEM_A, 4'hF, MEM_D);
        checkOutput("memWrite", 0, 1, 1, 4'hF, MEM_A, MEM_D);
        applyStimulus(0, 0, 0, 32'h0, 1, MEM_A, 4'h0, 32'h0);
        checkOutput("memRead", 0, 1, 1, 4'h0, MEM_A, 32'h0);
        expectRsp(0, MEM_D);
        idleCycle("memIdle");

        // Byte-enable write with fetch waiting, then read back the merge.
        applyStimulus(0, 0, 1, IF_A, 1, 32'h200, 4'b0011, 32'h0000_ABCD);
        checkOutput("byteWrite", 0, 1, 1, 4'b0011, 32'h200, 32'h0000_ABCD);
        applyStimulus(0, 0, 0, 32'h0, 1, 32'h200, 4'h0, 32'h0);
        checkOutput("byteRead", 0, 1, 1, 4'h0, 32'h200, 32'h0);
        expectRsp(0, 32'h1122_ABCD);
        idleCycle("byteIdle");

        // Contention: fetch forced after four consecutive memory grants.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 1, IF_A, 1, MEM_A, 4'h0, 32'h0);
            checkOutput($sformatf("contend%0d", i), !expMemSeq[i], expMemSeq[i], 1, 4'h0,
                        expMemSeq[i] ? MEM_A : IF_A, 32'h0);
            if (expMemSeq[i]) expectRsp(0, MEM_D);
            else              expectRsp(1, IF_D);
        end
        idleCycle("contendIdle");

        // Cancel in the grant cycle suppresses the fetch response.
        applyStimulus(0, 1, 1, IF_A, 0, 32'h0, 4'h0, 32'h0);
        checkOutput("cancelGrant", 1, 0, 1, 4'h0, IF_A, 32'h0);
        idleCycle("cancelIdle0");
        // Cancel in the response cycle also suppresses it; memory read unaffected.
        applyStimulus(0, 0, 1, IF_A, 0, 32'h0, 4'h0, 32'h0);
        checkOutput("fetchBeforeCancel", 1, 0, 1, 4'h0, IF_A, 32'h0);
        applyStimulus(0, 1, 0, 32'h0, 1, MEM_A, 4'h0, 32'h0);
        checkOutput("memReadOnCancel", 0, 1, 1, 4'h0, MEM_A, 32'h0);
        expectRsp(0, MEM_D);
        idleCycle("cancelIdle1");

        // Reset mid-read drops the response and clears the starvation count.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, IF_A, 1, MEM_A, 4'h0, 32'h0);
            checkOutput($sformatf("preReset%0d", i), 0, 1, 1, 4'h0, MEM_A, 32'h0);
            if (i < 2) expectRsp(0, MEM_D);
        end
        applyStimulus(1, 0, 1, IF_A, 1, MEM_A, 4'h0, 32'h0);
        checkOutput("midReset0", 0, 0, 0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1, 0, 1, IF_A, 1, MEM_A, 4'h0, 32'h0);
        checkOutput("midReset1", 0, 0, 0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, IF_A, 1, MEM_A, 4'h0, 32'h0);
            checkOutput($sformatf("postReset%0d", i), !expMemSeq[i], expMemSeq[i], 1, 4'h0,
                        expMemSeq[i] ? MEM_A : IF_A, 32'h0);
            if (expMemSeq[i]) expectRsp(0, MEM_D);
            else              expectRsp(1, IF_D);
        end
        idleCycle("finalIdle0");
        idleCycle("finalIdle1");

        // Every expected response must have been delivered.
        assertCount++;
        if (expQ.size() != 0) begin
            failCount++;
            $display("[TB] FAIL pendingRsp: %0d responses outstanding, required 0", expQ.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
